// File: rtl/response_sender_pkg.sv
// response_sender_pkg: shared state encoding, default rates and info field layout
package response_sender_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, ACK, WAIT_LOW} state_t;
  localparam int DEFAULT_CLK_FREQ = 50_000_000;
  localparam int DEFAULT_BAUD = 9600;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W = 5;
  localparam int CODE_LSB = 5;
  localparam int CODE_W = 4;
  localparam int DATA_LSB = 9;
  localparam int DATA_W = 7;
  function automatic int timerWidth(input int clksPerBit);
    return clksPerBit > 1 ? $clog2(clksPerBit) : 1;
  endfunction
endpackage

// File: rtl/response_sender_uart_tx_byte.sv
// uart_tx_byte: 8N1 LSB-first serializer; data is read live so the caller's register stays the source
module uart_tx_byte
  import response_sender_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLK_FREQ / DEFAULT_BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       done,
  output logic       tx
);
  localparam int TW = timerWidth(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
  state_t state;
  logic [TW-1:0] timer;
  logic [2:0] bitIdx;
  logic [2:0] nextIdx;
  logic bitEnd;
  assign bitEnd = timer == LAST;
  assign nextIdx = bitIdx + 3'd1;
  assign done = state == STOP && bitEnd;
  // a start accepted during the last stop clock chains the next byte with no idle gap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      tx <= 1'b1;
      timer <= '0;
      bitIdx <= '0;
    end else if (start && (state == IDLE || done)) begin
      state <= START;
      tx <= 1'b0;
      timer <= '0;
      bitIdx <= '0;
    end else if (state != IDLE) begin
      timer <= bitEnd ? '0 : timer + 1'b1;
      if (bitEnd) begin
        state <= state == START ? DATA : state == DATA ? (bitIdx != 3'd7 ? DATA : STOP) : IDLE;
        tx <= state == START ? data[0] : state == DATA && bitIdx != 3'd7 ? data[nextIdx] : 1'b1;
        bitIdx <= state == DATA ? nextIdx : bitIdx;
      end
    end
endmodule

// File: rtl/response_sender.sv
// response_sender: captures a DHT11 response word, sends it as two UART bytes and handshakes completion
module response_sender
  import response_sender_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int BAUD = DEFAULT_BAUD,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        buffer_pronto,
  input  logic [15:0] info,
  output logic        buffer_usado,
  output logic        tx,
  output logic        busy
);
  state_t state;
  logic [15:0] held;
  logic byteSel;
  logic start;
  logic done;
  assign start = state == IDLE ? buffer_pronto : state == START && done && !byteSel;
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) txByte (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .data  (byteSel ? held[15:8] : held[7:0]),
    .done  (done),
    .tx    (tx)
  );
  // START here covers the whole two-byte frame; the serializer tracks the bit phases
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      held <= '0;
      byteSel <= 1'b0;
      busy <= 1'b0;
      buffer_usado <= 1'b0;
    end else begin
      buffer_usado <= state == START && done && byteSel;
      if (state == IDLE && buffer_pronto) begin
        state <= START;
        held <= info;
        byteSel <= 1'b0;
        busy <= 1'b1;
      end else if (state == START && done) begin
        state <= byteSel ? ACK : START;
        byteSel <= 1'b1;
      end else if (state == ACK) begin
        state <= WAIT_LOW;
      end else if (state == WAIT_LOW && !buffer_pronto) begin
        state <= IDLE;
        busy <= 1'b0;
      end
    end
endmodule

// File: tb/tb_response_sender.sv
// tb_response_sender: table-driven and random checks of response_sender against a bit-level frame model
module tb_response_sender;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic buffer_pronto = 1'b0;
  logic [15:0] info = 16'h0000;
  logic buffer_usado;
  logic tx;
  logic busy;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] word;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          hold;
    bit          chg;
    bit          tog;
  } vec_t;
  vec_t vecs[6];

  response_sender #(.CLKS_PER_BIT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .buffer_pronto (buffer_pronto),
    .info          (info),
    .buffer_usado  (buffer_usado),
    .tx            (tx),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // line level at clock i (0..79) of a frame: 20 bit slots of 4 clocks, 10 slots per byte
  function automatic logic expBit(input logic [7:0] b0, input logic [7:0] b1, input int i);
    int p;
    logic [7:0] b;
    p = (i / 4) % 10;
    b = i < 40 ? b0 : b1;
    return p == 0 ? 1'b0 : p == 9 ? 1'b1 : b[p-1];
  endfunction

  // called at a negedge; raises buffer_pronto and follows one response through to re-arm
  task automatic send(input logic [15:0] word, input logic [7:0] b0, input logic [7:0] b1,
                      input int hold, input bit chg, input bit tog);
    int n;
    info = word;
    buffer_pronto = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      check("tx_frame", tx, expBit(b0, b1, i));
      check("busy_frame", busy, 1'b1);
      check("usado_frame", buffer_usado, 1'b0);
      if (chg && i == 20) info = 16'hFFFF;
      if (tog && i == 10) buffer_pronto = 1'b0;
      if (tog && i == 30) buffer_pronto = 1'b1;
    end
    @(negedge clk);
    check("usado_pulse", buffer_usado, 1'b1);
    check("tx_ack", tx, 1'b1);
    check("busy_ack", busy, 1'b1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("usado_once", buffer_usado, 1'b0);
      check("busy_wait_low", busy, 1'b1);
      check("tx_wait_low", tx, 1'b1);
    end
    buffer_pronto = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 4);
    check("busy_fall", busy, 1'b0);
    check("usado_idle", buffer_usado, 1'b0);
    check("tx_idle", tx, 1'b1);
  endtask

  initial begin
    vecs[0] = '{16'hA5C3, 8'hC3, 8'hA5, 2, 1'b0, 1'b0};
    vecs[1] = '{16'hA5C3, 8'hC3, 8'hA5, 1, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 8'h00, 8'h00, 0, 1'b0, 1'b1};
    vecs[3] = '{16'h0123, 8'h23, 8'h01, 1, 1'b0, 1'b0};
    vecs[4] = '{16'hFE10, 8'h10, 8'hFE, 3, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 8'hFF, 8'hFF, 1, 1'b0, 1'b1};

    buffer_pronto = 1'b1;
    info = 16'h1234;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_usado", buffer_usado, 1'b0);
    buffer_pronto = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_tx", tx, 1'b1);

    foreach (vecs[k]) send(vecs[k].word, vecs[k].b0, vecs[k].b1, vecs[k].hold, vecs[k].chg, vecs[k].tog);

    // reset during byte 1 data bit 3, then restart with buffer_pronto still high
    info = 16'hA5C3;
    buffer_pronto = 1'b1;
    for (int i = 0; i < 58; i++) begin
      @(negedge clk);
      check("tx_pre_reset", tx, expBit(8'hC3, 8'hA5, i));
    end
    rst_n = 1'b0;
    #1;
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_usado", buffer_usado, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("abort_hold_usado", buffer_usado, 1'b0);
      check("abort_hold_tx", tx, 1'b1);
    end
    rst_n = 1'b1;
    send(16'hA5C3, 8'hC3, 8'hA5, 1, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      logic [15:0] w;
      w = 16'($urandom);
      send(w, w[7:0], w[15:8], int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (5) begin
      @(negedge clk);
      check("final_idle_tx", tx, 1'b1);
      check("final_idle_busy", busy, 1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
